// File: rtl/gal22v10_io_core.sv
// rtl/gal22v10_io_core.sv - GAL22V10 fuse-programmed logic core with ten OLMCs
// AND array, per-OLMC sum/polarity/register stage and tri-state pins.

package gal22v10_io_pkg;

    localparam int COLS      = 44;
    localparam int ROWS      = 132;
    localparam int AND_BITS  = 5808;
    localparam int FUSE_BITS = 5828;
    localparam int SP_ROW    = 131;

    function automatic int olmc_rows(input int k);
        case (k)
            0, 9:    return 8;
            1, 8:    return 10;
            2, 7:    return 12;
            3, 6:    return 14;
            default: return 16;
        endcase
    endfunction

    // OLMC blocks are stacked from IOQ9 downward, starting right after the AR row.
    function automatic int olmc_oe_row(input int k);
        int r;
        r = 1;
        for (int j = 9; j > k; j--) begin
            r = r + 1 + olmc_rows(j);
        end
        return r;
    endfunction

    function automatic int i_true_col(input int n);
        if (n < 10) begin
            return 4 * n;
        end else if (n == 10) begin
            return 40;
        end
        return 42;
    endfunction

    function automatic logic [FUSE_BITS-1:0] default_fuses();
        logic [FUSE_BITS-1:0] f;
        int                   oe;
        f = '0;
        for (int k = 0; k < 10; k++) begin
            oe = olmc_oe_row(k);
            f[oe*COLS +: COLS]                     = '1;
            f[(oe+1)*COLS +: COLS]                 = '1;
            f[(oe+1)*COLS + i_true_col(k+1)]       = 1'b0;
            f[AND_BITS + 2*k]                      = 1'b1;
            f[AND_BITS + 2*k + 1]                  = 1'b1;
        end
        return f;
    endfunction

endpackage

module gal22v10_io_core
    import gal22v10_io_pkg::*;
#(
    parameter logic [FUSE_BITS-1:0] FUSES = default_fuses()
) (
    input  logic [11:0] i,
    inout  wire  [9:0]  ioq,
    input  logic        vcc,
    input  logic        gnd
);

    logic [23:0]     lit_i;
    logic [9:0]      fb;
    logic [ROWS-1:0] pt;
    logic [9:0]      sum;
    logic [9:0]      d;
    logic [9:0]      out;
    logic [9:0]      oe;
    logic [9:0]      q = '0;
    logic            power_ok;

    assign power_ok = vcc & ~gnd;

    for (genvar n = 0; n < 12; n++) begin : g_lit
        assign lit_i[2*n]     = i[n];
        assign lit_i[2*n + 1] = ~i[n];
    end

    // Each literal is ORed with its own constant fuse bit so that open fuses fold
    // away entirely, leaving no structural path from unused feedback columns.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [COLS-1:0] used;
        for (genvar c = 0; c < COLS; c++) begin : g_col
            if (c >= 40) begin : g_i10_i11
                assign used[c] = FUSES[r*COLS + c] | lit_i[20 + (c - 40)];
            end else if ((c % 4) < 2) begin : g_in
                assign used[c] = FUSES[r*COLS + c] | lit_i[2*(c/4) + (c % 4)];
            end else if ((c % 4) == 2) begin : g_fb_t
                assign used[c] = FUSES[r*COLS + c] | fb[9 - c/4];
            end else begin : g_fb_c
                assign used[c] = FUSES[r*COLS + c] | ~fb[9 - c/4];
            end
        end
        assign pt[r] = &used;
    end

    for (genvar k = 0; k < 10; k++) begin : g_olmc
        localparam int OE_ROW = olmc_oe_row(k);
        localparam int N      = olmc_rows(k);
        localparam bit S0     = FUSES[AND_BITS + 2*k];
        localparam bit S1     = FUSES[AND_BITS + 2*k + 1];

        assign sum[k] = |pt[OE_ROW+1 +: N];
        assign d[k]   = S0 ? sum[k] : ~sum[k];
        assign out[k] = S1 ? d[k] : q[k];
        assign oe[k]  = pt[OE_ROW];
        // Combinational cells feed back the pin itself, so an external driver is
        // seen while the output is disabled; registered cells feed back Q.
        assign fb[k]  = S1 ? ioq[k] : q[k];
        assign ioq[k] = (power_ok && oe[k]) ? out[k] : 1'bz;
    end

    always_ff @(posedge i[0]) begin
        if (pt[0]) begin
            q <= '0;
        end else if (pt[SP_ROW]) begin
            q <= '1;
        end else begin
            q <= d;
        end
    end

endmodule

// File: tb/tb_gal22v10_io_core.sv
// tb/tb_gal22v10_io_core.sv - directed self-checking bench for gal22v10_io_core

module tb_gal22v10_io_core;

    localparam int AB = 5808;

    logic [11:0] i;
    logic        vcc;
    logic        gnd;
    wire  [9:0]  ioq_def_pu;
    wire  [9:0]  ioq_def_pd;
    wire  [9:0]  ioq_inv;
    wire  [9:0]  ioq_reg;
    wire  [9:0]  ioq_oe_pu;
    wire  [9:0]  ioq_oe_pd;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Pull-up / pull-down twins reveal a released pin as a disagreement.
    for (genvar b = 0; b < 10; b++) begin : g_pull
        pullup   (ioq_def_pu[b]);
        pulldown (ioq_def_pd[b]);
        pullup   (ioq_oe_pu[b]);
        pulldown (ioq_oe_pd[b]);
    end

    function automatic int oe_row(input int k);
        case (k)
            9:       return 1;
            8:       return 10;
            7:       return 21;
            6:       return 34;
            5:       return 49;
            4:       return 66;
            3:       return 83;
            2:       return 98;
            1:       return 111;
            default: return 122;
        endcase
    endfunction

    function automatic int in_col(input int n);
        if (n <= 9) return 4 * n;
        if (n == 10) return 40;
        return 42;
    endfunction

    function automatic logic [5827:0] make_map(input bit s0_0, input bit s1_0,
                                               input bit ar_sp, input bit oe9);
        logic [5827:0] m;
        int            r;
        m = '0;
        for (int k = 0; k < 10; k++) begin
            r = oe_row(k);
            m[r*44 +: 44]               = '1;
            m[(r+1)*44 +: 44]           = '1;
            m[(r+1)*44 + in_col(k+1)]   = 1'b0;
            m[AB + 2*k]                 = 1'b1;
            m[AB + 2*k + 1]             = 1'b1;
        end
        m[AB]     = s0_0;
        m[AB + 1] = s1_0;
        if (ar_sp) begin
            m[0 +: 44]             = '1;
            m[in_col(2)]           = 1'b0;
            m[131*44 +: 44]        = '1;
            m[131*44 + in_col(3)]  = 1'b0;
        end
        if (oe9) begin
            m[oe_row(9)*44 +: 44]           = '1;
            m[oe_row(9)*44 + in_col(11)]    = 1'b0;
        end
        return m;
    endfunction

    localparam logic [5827:0] MAP_INV = make_map(1'b0, 1'b1, 1'b0, 1'b0);
    localparam logic [5827:0] MAP_REG = make_map(1'b1, 1'b0, 1'b1, 1'b0);
    localparam logic [5827:0] MAP_OE  = make_map(1'b1, 1'b1, 1'b0, 1'b1);

    gal22v10_io_core u_def_pu (.i(i), .ioq(ioq_def_pu), .vcc(vcc), .gnd(gnd));
    gal22v10_io_core u_def_pd (.i(i), .ioq(ioq_def_pd), .vcc(vcc), .gnd(gnd));
    gal22v10_io_core #(.FUSES(MAP_INV)) u_inv (.i(i), .ioq(ioq_inv), .vcc(vcc), .gnd(gnd));
    gal22v10_io_core #(.FUSES(MAP_REG)) u_reg (.i(i), .ioq(ioq_reg), .vcc(vcc), .gnd(gnd));
    gal22v10_io_core #(.FUSES(MAP_OE))  u_oe_pu (.i(i), .ioq(ioq_oe_pu), .vcc(vcc), .gnd(gnd));
    gal22v10_io_core #(.FUSES(MAP_OE))  u_oe_pd (.i(i), .ioq(ioq_oe_pd), .vcc(vcc), .gnd(gnd));

    task automatic tick();
        i[0] = 1'b1;
        #5;
        i[0] = 1'b0;
        #5;
    endtask

    task automatic test_reset();
        total_cnt++;
        if (ioq_reg[0] !== 1'b0)
            $display("FAIL reset_q0 got %b want 0", ioq_reg[0]);
        else pass_cnt++;
        total_cnt++;
        if (ioq_def_pu !== 10'h000 || ioq_def_pd !== 10'h000)
            $display("FAIL reset_default got %h/%h want 000", ioq_def_pu, ioq_def_pd);
        else pass_cnt++;
    endtask

    task automatic test_sweep();
        logic [9:0] exp;
        for (int v = 0; v < 4096; v++) begin
            i = v[11:0];
            #100;
            exp = v[10:1];
            total_cnt++;
            if (ioq_def_pu !== exp || ioq_def_pd !== exp)
                $display("FAIL sweep i=%h got %h/%h want %h", v[11:0], ioq_def_pu, ioq_def_pd, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_patterns();
        i = 12'hAAA;
        #10;
        total_cnt++;
        if (ioq_def_pu !== 10'h155 || ioq_def_pd !== 10'h155)
            $display("FAIL pattern_aaa got %h/%h want 155", ioq_def_pu, ioq_def_pd);
        else pass_cnt++;
        i = 12'h555;
        #10;
        total_cnt++;
        if (ioq_def_pu !== 10'h2AA || ioq_def_pd !== 10'h2AA)
            $display("FAIL pattern_555 got %h/%h want 2aa", ioq_def_pu, ioq_def_pd);
        else pass_cnt++;
    endtask

    task automatic test_invert();
        i = 12'h002;
        #10;
        total_cnt++;
        if (ioq_inv !== 10'h000)
            $display("FAIL invert_i1_high got %h want 000", ioq_inv);
        else pass_cnt++;
        i = 12'h000;
        #10;
        total_cnt++;
        if (ioq_inv !== 10'h001)
            $display("FAIL invert_i1_low got %h want 001", ioq_inv);
        else pass_cnt++;
    endtask

    task automatic test_registered();
        i = 12'h000;
        #5;
        i[2] = 1'b1;
        tick();
        total_cnt++;
        if (ioq_reg[0] !== 1'b0) $display("FAIL reg_ar_init got %b want 0", ioq_reg[0]);
        else pass_cnt++;
        i[2] = 1'b0;
        i[1] = 1'b1;
        #10;
        total_cnt++;
        if (ioq_reg[0] !== 1'b0) $display("FAIL reg_hold_before_edge got %b want 0", ioq_reg[0]);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ioq_reg[0] !== 1'b1) $display("FAIL reg_capture got %b want 1", ioq_reg[0]);
        else pass_cnt++;
        i[1] = 1'b0;
        #10;
        total_cnt++;
        if (ioq_reg[0] !== 1'b1) $display("FAIL reg_hold_no_edge got %b want 1", ioq_reg[0]);
        else pass_cnt++;
        i[1] = 1'b1;
        i[2] = 1'b1;
        tick();
        total_cnt++;
        if (ioq_reg[0] !== 1'b0) $display("FAIL reg_ar got %b want 0", ioq_reg[0]);
        else pass_cnt++;
        total_cnt++;
        if (ioq_reg[1] !== 1'b1 || ioq_reg[5] !== 1'b0)
            $display("FAIL reg_comb_unaffected got %b%b want 10", ioq_reg[1], ioq_reg[5]);
        else pass_cnt++;
        i[1] = 1'b0;
        i[2] = 1'b0;
        i[3] = 1'b1;
        tick();
        total_cnt++;
        if (ioq_reg[0] !== 1'b1) $display("FAIL reg_sp got %b want 1", ioq_reg[0]);
        else pass_cnt++;
        i[1] = 1'b1;
        i[2] = 1'b1;
        i[3] = 1'b1;
        tick();
        total_cnt++;
        if (ioq_reg[0] !== 1'b0) $display("FAIL reg_ar_over_sp got %b want 0", ioq_reg[0]);
        else pass_cnt++;
        i[2] = 1'b0;
        #10;
        total_cnt++;
        if (ioq_reg[0] !== 1'b0) $display("FAIL reg_ar_release_no_edge got %b want 0", ioq_reg[0]);
        else pass_cnt++;
        tick();
        i[2] = 1'b1;
        #10;
        total_cnt++;
        if (ioq_reg[0] !== 1'b1) $display("FAIL reg_ar_assert_no_edge got %b want 1", ioq_reg[0]);
        else pass_cnt++;
    endtask

    task automatic test_oe();
        i = 12'h400;
        #10;
        total_cnt++;
        if (ioq_oe_pu[9] !== 1'b1 || ioq_oe_pd[9] !== 1'b0)
            $display("FAIL oe_disabled got %b/%b want 1/0", ioq_oe_pu[9], ioq_oe_pd[9]);
        else pass_cnt++;
        i = 12'hC00;
        #10;
        total_cnt++;
        if (ioq_oe_pu[9] !== 1'b1 || ioq_oe_pd[9] !== 1'b1)
            $display("FAIL oe_enabled_high got %b/%b want 1/1", ioq_oe_pu[9], ioq_oe_pd[9]);
        else pass_cnt++;
        i = 12'h800;
        #10;
        total_cnt++;
        if (ioq_oe_pu[9] !== 1'b0 || ioq_oe_pd[9] !== 1'b0)
            $display("FAIL oe_enabled_low got %b/%b want 0/0", ioq_oe_pu[9], ioq_oe_pd[9]);
        else pass_cnt++;
    endtask

    task automatic test_power();
        i = 12'hAAA;
        vcc = 1'b0;
        #10;
        total_cnt++;
        if (ioq_def_pu !== 10'h3FF || ioq_def_pd !== 10'h000)
            $display("FAIL power_vcc_off got %h/%h want 3ff/000", ioq_def_pu, ioq_def_pd);
        else pass_cnt++;
        vcc = 1'b1;
        gnd = 1'b1;
        #10;
        total_cnt++;
        if (ioq_def_pu !== 10'h3FF || ioq_def_pd !== 10'h000)
            $display("FAIL power_gnd_high got %h/%h want 3ff/000", ioq_def_pu, ioq_def_pd);
        else pass_cnt++;
        gnd = 1'b0;
        #10;
        total_cnt++;
        if (ioq_def_pu !== 10'h155 || ioq_def_pd !== 10'h155)
            $display("FAIL power_restored got %h/%h want 155", ioq_def_pu, ioq_def_pd);
        else pass_cnt++;
    endtask

    initial begin
        i   = 12'h000;
        vcc = 1'b1;
        gnd = 1'b0;
        #1;
        test_reset();
        test_sweep();
        test_patterns();
        test_invert();
        test_registered();
        test_oe();
        test_power();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
